// File: rtl/instruction_issue_unit_if.sv
// Handshake bundle between the issue unit, its program memory and the core.
// Optional perf-counter outputs exist only when ISSUE_PERF_COUNTERS_EN is defined.
interface instruction_issue_unit_if #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDR_WIDTH        = 16
);
  logic                         runStart;
  logic [ADDR_WIDTH-1:0]        programLength;
  logic [ADDR_WIDTH-1:0]        memAddr;
  logic [INSTRUCTION_WIDTH-1:0] memData;
  logic [INSTRUCTION_WIDTH-1:0] instructionIn;
  logic                         start;
  logic                         busy;
  logic                         running;
  logic                         done;
`ifdef ISSUE_PERF_COUNTERS_EN
  logic [31:0]                  cycleCount;
  logic [ADDR_WIDTH-1:0]        issuedCount;

  modport master (
    input  runStart, programLength, memData, busy,
    output memAddr, instructionIn, start, running, done, cycleCount, issuedCount
  );
  modport slave (
    output runStart, programLength, memData, busy,
    input  memAddr, instructionIn, start, running, done, cycleCount, issuedCount
  );
`else
  modport master (
    input  runStart, programLength, memData, busy,
    output memAddr, instructionIn, start, running, done
  );
  modport slave (
    output runStart, programLength, memData, busy,
    input  memAddr, instructionIn, start, running, done
  );
`endif
endinterface

// File: rtl/instruction_issue_unit.sv
// Sequences a program from synchronous-read memory into the core's start/busy handshake.
// Define ISSUE_PERF_COUNTERS_EN to add saturating cycleCount / issuedCount outputs.
module instruction_issue_unit #(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int ADDR_WIDTH        = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  instruction_issue_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e                       state_q, state_d;
  logic [ADDR_WIDTH-1:0]        pc_q, pc_d;
  logic [ADDR_WIDTH-1:0]        length_q, length_d;
  logic [ADDR_WIDTH-1:0]        mem_addr_q, mem_addr_d;
  logic [INSTRUCTION_WIDTH-1:0] instr_q, instr_d;

  logic [ADDR_WIDTH-1:0]        pc_inc;
  logic                         run_accept;
  logic                         issue_accept;

  assign pc_inc       = pc_q + ADDR_WIDTH'(1);
  assign run_accept   = ((state_q == S_IDLE) || (state_q == S_DONE)) && bus.runStart;
  assign issue_accept = (state_q == S_ISSUE) && !bus.busy;

  // NOTE: every always_comb output gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    length_d   = length_q;
    mem_addr_d = mem_addr_q;
    instr_d    = instr_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.runStart) begin
          length_d   = bus.programLength;
          pc_d       = '0;
          mem_addr_d = '0;
          state_d    = (bus.programLength == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        // Address was presented last cycle, so read data is valid on this edge.
        instr_d = bus.memData;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (!bus.busy) begin
          pc_d = pc_inc;
          if (pc_inc == length_q) begin
            state_d = S_DRAIN;
          end else begin
            mem_addr_d = pc_inc;
            state_d    = S_FETCH;
          end
        end
      end
      S_DRAIN: begin
        // Entry edge never counts, so a busy raised right after the last accept is observed.
        if (!bus.busy) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= '0;
      length_q   <= '0;
      mem_addr_q <= '0;
      instr_q    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      length_q   <= length_d;
      mem_addr_q <= mem_addr_d;
      instr_q    <= instr_d;
    end
  end

  assign bus.memAddr       = mem_addr_q;
  assign bus.instructionIn = instr_q;
  assign bus.start         = (state_q == S_ISSUE);
  assign bus.running       = (state_q == S_FETCH) || (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign bus.done          = (state_q == S_DONE);

`ifdef ISSUE_PERF_COUNTERS_EN
  logic [31:0]           cycle_count_q, cycle_count_d;
  logic [ADDR_WIDTH-1:0] issued_count_q, issued_count_d;

  always_comb begin
    cycle_count_d  = cycle_count_q;
    issued_count_d = issued_count_q;
    if (run_accept) begin
      cycle_count_d  = '0;
      issued_count_d = '0;
    end else begin
      if (bus.running && (cycle_count_q != '1)) cycle_count_d = cycle_count_q + 32'd1;
      if (issue_accept && (issued_count_q != '1)) issued_count_d = issued_count_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_count_q  <= '0;
      issued_count_q <= '0;
    end else begin
      cycle_count_q  <= cycle_count_d;
      issued_count_q <= issued_count_d;
    end
  end

  assign bus.cycleCount  = cycle_count_q;
  assign bus.issuedCount = issued_count_q;
`else
  // Accept strobes only feed the counters; keep them referenced in the base build.
  logic unused_accepts;
  assign unused_accepts = run_accept ^ issue_accept;
`endif

endmodule

// File: tb/tb_instruction_issue_unit.sv
// Bench for instruction_issue_unit: directed cycle table, hand-built corner runs, random runs
// scored against a transaction-level model (expected word order, hold, gap and drain rules).
module tb_instruction_issue_unit;

  localparam int IW = 32;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  instruction_issue_unit_if #(.INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  instruction_issue_unit #(.INSTRUCTION_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [IW-1:0] mem [64];
  assign bus.memData = mem[bus.memAddr[5:0]];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rst_n;
    logic          run;
    logic [AW-1:0] len;
    logic          busy;
    logic          e_start;
    logic          e_running;
    logic          e_done;
    logic [AW-1:0] e_addr;
    logic [IW-1:0] e_instr;
  } vec_t;

  vec_t vecs[30];

  // One program run scored against the rules: words in order, hold under busy,
  // a non-start cycle after every accept, done on the first busy-low edge after the last accept.
  // mode: 0 random busy + ignored runStart noise, 1 backpressure, 2 drain wait,
  //       3 runStart pulse during ISSUE, 4 busy tied low.
  task automatic run_prog(input int len, input int mode);
    int          accepts;
    int          ticks;
    int          since_acc;
    logic        released;
    logic        pulsed;
    logic        hold;
    logic        acc_now;
    logic [IW-1:0] held_instr;

    bus.runStart      = 1'b1;
    bus.programLength = AW'(len);
    bus.busy          = 1'b0;
    tick();
    bus.runStart = 1'b0;
    check("after_runstart_done", 32'(bus.done), 32'(len == 0));
    check("after_runstart_addr", 32'(bus.memAddr), 32'd0);
    check("after_runstart_start", 32'(bus.start), 32'd0);

    if (len == 0) begin
      tick();
      check("zero_len_no_start", 32'(bus.start), 32'd0);
      check("zero_len_done", 32'(bus.done), 32'd1);
`ifdef ISSUE_PERF_COUNTERS_EN
      check("zero_len_issued", 32'(bus.issuedCount), 32'd0);
      check("zero_len_cycles", bus.cycleCount, 32'd0);
`endif
      return;
    end

    accepts   = 0;
    ticks     = 0;
    since_acc = 0;
    released  = 1'b0;
    pulsed    = 1'b0;
    while (!bus.done && ticks < 500) begin
      bus.runStart = 1'b0;
      case (mode)
        0: begin
          bus.busy          = ($urandom_range(0, 2) == 0);
          bus.runStart      = ($urandom_range(0, 9) == 0);
          bus.programLength = AW'($urandom);
        end
        1: bus.busy = (accepts == 1) && (since_acc >= 1) && (since_acc <= 4);
        2: bus.busy = (accepts == len) && (since_acc >= 1) && (since_acc <= 5);
        3: begin
          bus.busy = 1'b0;
          if (!pulsed && bus.start && accepts == 1) begin
            bus.runStart      = 1'b1;
            bus.programLength = AW'(9);
            pulsed            = 1'b1;
          end
        end
        default: bus.busy = 1'b0;
      endcase

      acc_now = bus.start && !bus.busy;
      if (acc_now) begin
        if (accepts < 64) check("issued_word", bus.instructionIn, mem[accepts]);
        accepts++;
      end
      if (accepts == len && !acc_now && !bus.busy) released = 1'b1;
      hold       = bus.start && bus.busy;
      held_instr = bus.instructionIn;

      tick();
      ticks++;
      since_acc = acc_now ? 1 : since_acc + 1;

      if (hold) begin
        check("hold_start", 32'(bus.start), 32'd1);
        check("hold_word", bus.instructionIn, held_instr);
      end
      if (acc_now) check("gap_after_accept", 32'(bus.start), 32'd0);
      check("done_timing", 32'(bus.done), 32'(released));
      check("running_flag", 32'(bus.running), 32'(!released));
      if (bus.running) check("addr_in_range", 32'(bus.memAddr < AW'(len)), 32'd1);
    end
    bus.runStart = 1'b0;
    bus.busy     = 1'b0;

    check("accept_count", 32'(accepts), 32'(len));
    check("run_completes", 32'(bus.done), 32'd1);
`ifdef ISSUE_PERF_COUNTERS_EN
    check("perf_issued", 32'(bus.issuedCount), 32'(len));
    check("perf_cycles", bus.cycleCount, 32'(ticks));
`endif
  endtask

  initial begin
    reset             = 1'b0;
    bus.runStart      = 1'b0;
    bus.programLength = '0;
    bus.busy          = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | 32'(i);
    mem[0] = 32'h11;
    mem[1] = 32'h22;
    mem[2] = 32'h33;

    //          rst run len busy | start run done addr instr
    vecs[0]  = '{0, 0, 0, 0,  0, 0, 0, 0, 32'h00};
    vecs[1]  = '{1, 0, 0, 0,  0, 0, 0, 0, 32'h00};
    vecs[2]  = '{1, 1, 3, 0,  0, 1, 0, 0, 32'h00};
    vecs[3]  = '{1, 0, 0, 0,  1, 1, 0, 0, 32'h11};
    vecs[4]  = '{1, 0, 0, 0,  0, 1, 0, 1, 32'h11};
    vecs[5]  = '{1, 0, 0, 0,  1, 1, 0, 1, 32'h22};
    vecs[6]  = '{1, 0, 0, 0,  0, 1, 0, 2, 32'h22};
    vecs[7]  = '{1, 0, 0, 0,  1, 1, 0, 2, 32'h33};
    vecs[8]  = '{1, 0, 0, 0,  0, 1, 0, 2, 32'h33};
    vecs[9]  = '{1, 0, 0, 0,  0, 0, 1, 2, 32'h33};
    vecs[10] = '{1, 0, 0, 0,  0, 0, 1, 2, 32'h33};
    vecs[11] = '{1, 1, 2, 0,  0, 1, 0, 0, 32'h33};
    vecs[12] = '{1, 0, 0, 0,  1, 1, 0, 0, 32'h11};
    vecs[13] = '{1, 0, 0, 1,  1, 1, 0, 0, 32'h11};
    vecs[14] = '{1, 0, 0, 0,  0, 1, 0, 1, 32'h11};
    vecs[15] = '{1, 0, 0, 0,  1, 1, 0, 1, 32'h22};
    vecs[16] = '{1, 0, 0, 0,  0, 1, 0, 1, 32'h22};
    vecs[17] = '{1, 0, 0, 1,  0, 1, 0, 1, 32'h22};
    vecs[18] = '{1, 0, 0, 0,  0, 0, 1, 1, 32'h22};
    vecs[19] = '{1, 1, 5, 0,  0, 1, 0, 0, 32'h22};
    vecs[20] = '{1, 0, 0, 0,  1, 1, 0, 0, 32'h11};
    vecs[21] = '{1, 0, 0, 0,  0, 1, 0, 1, 32'h11};
    vecs[22] = '{1, 0, 0, 0,  1, 1, 0, 1, 32'h22};
    vecs[23] = '{1, 0, 0, 0,  0, 1, 0, 2, 32'h22};
    vecs[24] = '{1, 0, 0, 0,  1, 1, 0, 2, 32'h33};
    vecs[25] = '{0, 0, 0, 0,  0, 0, 0, 0, 32'h00};
    vecs[26] = '{1, 0, 0, 0,  0, 0, 0, 0, 32'h00};
    vecs[27] = '{1, 0, 0, 1,  0, 0, 0, 0, 32'h00};
    vecs[28] = '{1, 1, 0, 0,  0, 0, 1, 0, 32'h00};
    vecs[29] = '{1, 0, 0, 0,  0, 0, 1, 0, 32'h00};

    #2;
    for (int i = 0; i < 30; i++) begin
      reset             = vecs[i].rst_n;
      bus.runStart      = vecs[i].run;
      bus.programLength = vecs[i].len;
      bus.busy          = vecs[i].busy;
      tick();
      check($sformatf("vec%0d_start", i), 32'(bus.start), 32'(vecs[i].e_start));
      check($sformatf("vec%0d_running", i), 32'(bus.running), 32'(vecs[i].e_running));
      check($sformatf("vec%0d_done", i), 32'(bus.done), 32'(vecs[i].e_done));
      check($sformatf("vec%0d_addr", i), 32'(bus.memAddr), 32'(vecs[i].e_addr));
      check($sformatf("vec%0d_instr", i), bus.instructionIn, vecs[i].e_instr);
    end
    bus.runStart = 1'b0;
    bus.busy     = 1'b0;

    run_prog(3, 4);  // basic run, busy tied low
    run_prog(2, 1);  // backpressure across FETCH and second ISSUE
    run_prog(1, 2);  // drain waits for busy
    run_prog(4, 3);  // runStart during ISSUE ignored
    run_prog(0, 4);  // zero length
    run_prog(2, 4);  // restart from DONE

    for (int r = 0; r < 40; r++) begin
      int len;
      len = $urandom_range(0, 20);
      for (int k = 0; k < 64; k++) mem[k] = $urandom;
      run_prog(len, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
